// File: rtl/axi_mem_arbiter.sv
// axi_mem_arbiter
//   Shares one downstream AXI4 slave port between two upstream masters:
//     m0 = instruction fetch (read-only), m1 = load/store (read + write).
//   Only one transaction (AR + R burst, or AW + W + B) is in flight at a time,
//   because the downstream slaves hold a single address/length register set.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   m0_ar*, m0_r*     : m0 read address / read data channels
//   m1_ar*, m1_r*     : m1 read address / read data channels
//   m1_aw*, m1_w*,
//   m1_b*             : m1 write address / write data / write response
//   s_*               : downstream port (same channel set as m1, opposite
//                       directions)
//
// Grant is registered: a request seen in IDLE is forwarded downstream on the
// following cycle, and an IDLE cycle always separates two transactions.
module axi_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 64,
  parameter int IW      = 4,
  parameter bit WR_PRIO = 1'b1
) (
  input  logic            clk,
  input  logic            rst,

  // m0 read
  input  logic            m0_arvalid,
  output logic            m0_arready,
  input  logic [AW-1:0]   m0_araddr,
  input  logic [IW-1:0]   m0_arid,
  input  logic [7:0]      m0_arlen,
  input  logic [2:0]      m0_arsize,
  input  logic [1:0]      m0_arburst,
  output logic            m0_rvalid,
  input  logic            m0_rready,
  output logic [DW-1:0]   m0_rdata,
  output logic [1:0]      m0_rresp,
  output logic            m0_rlast,
  output logic [IW-1:0]   m0_rid,

  // m1 read
  input  logic            m1_arvalid,
  output logic            m1_arready,
  input  logic [AW-1:0]   m1_araddr,
  input  logic [IW-1:0]   m1_arid,
  input  logic [7:0]      m1_arlen,
  input  logic [2:0]      m1_arsize,
  input  logic [1:0]      m1_arburst,
  output logic            m1_rvalid,
  input  logic            m1_rready,
  output logic [DW-1:0]   m1_rdata,
  output logic [1:0]      m1_rresp,
  output logic            m1_rlast,
  output logic [IW-1:0]   m1_rid,

  // m1 write
  input  logic            m1_awvalid,
  output logic            m1_awready,
  input  logic [AW-1:0]   m1_awaddr,
  input  logic [IW-1:0]   m1_awid,
  input  logic [7:0]      m1_awlen,
  input  logic [2:0]      m1_awsize,
  input  logic [1:0]      m1_awburst,
  input  logic            m1_wvalid,
  output logic            m1_wready,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_wstrb,
  input  logic            m1_wlast,
  output logic            m1_bvalid,
  input  logic            m1_bready,
  output logic [1:0]      m1_bresp,
  output logic [IW-1:0]   m1_bid,

  // downstream
  output logic            s_arvalid,
  input  logic            s_arready,
  output logic [AW-1:0]   s_araddr,
  output logic [IW-1:0]   s_arid,
  output logic [7:0]      s_arlen,
  output logic [2:0]      s_arsize,
  output logic [1:0]      s_arburst,
  input  logic            s_rvalid,
  output logic            s_rready,
  input  logic [DW-1:0]   s_rdata,
  input  logic [1:0]      s_rresp,
  input  logic            s_rlast,
  input  logic [IW-1:0]   s_rid,
  output logic            s_awvalid,
  input  logic            s_awready,
  output logic [AW-1:0]   s_awaddr,
  output logic [IW-1:0]   s_awid,
  output logic [7:0]      s_awlen,
  output logic [2:0]      s_awsize,
  output logic [1:0]      s_awburst,
  output logic            s_wvalid,
  input  logic            s_wready,
  output logic [DW-1:0]   s_wdata,
  output logic [DW/8-1:0] s_wstrb,
  output logic            s_wlast,
  input  logic            s_bvalid,
  output logic            s_bready,
  input  logic [1:0]      s_bresp,
  input  logic [IW-1:0]   s_bid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD0  = 2'd1,
    RD1  = 2'd2,
    WR   = 2'd3
  } state_e;

  state_e     state_q, state_d;
  // Round-robin start point: 0 = m0 read, 1 = m1 read, 2 = m1 write.
  // With write priority only values 0 and 1 are ever used.
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic       ar_sent_q, ar_sent_d;
  logic       aw_sent_q, aw_sent_d;

  logic       ar_hs;
  logic       aw_hs;
  logic       r_done;
  logic       b_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr_q  <= 2'd0;
      ar_sent_q <= 1'b0;
      aw_sent_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      ar_sent_q <= ar_sent_d;
      aw_sent_q <= aw_sent_d;
    end
  end

  assign ar_hs  = s_arvalid & s_arready;
  assign aw_hs  = s_awvalid & s_awready;
  assign r_done = s_rvalid & s_rready & s_rlast;
  assign b_done = s_bvalid & s_bready;

  // Next-state: arbitration in IDLE, completion detection elsewhere.
  // The arbiter never counts beats; rlast and the B handshake end a transaction.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    ar_sent_d = ar_sent_q;
    aw_sent_d = aw_sent_q;

    case (state_q)
      IDLE: begin
        if (WR_PRIO) begin
          if (m1_awvalid) begin
            state_d = WR;
          end else if (m0_arvalid && m1_arvalid) begin
            state_d = (rr_ptr_q == 2'd0) ? RD0 : RD1;
          end else if (m0_arvalid) begin
            state_d = RD0;
          end else if (m1_arvalid) begin
            state_d = RD1;
          end
        end else begin
          // Three-way round robin, order m0 -> m1 read -> m1 write.
          case (rr_ptr_q)
            2'd1: begin
              if (m1_arvalid)      state_d = RD1;
              else if (m1_awvalid) state_d = WR;
              else if (m0_arvalid) state_d = RD0;
            end
            2'd2: begin
              if (m1_awvalid)      state_d = WR;
              else if (m0_arvalid) state_d = RD0;
              else if (m1_arvalid) state_d = RD1;
            end
            default: begin
              if (m0_arvalid)      state_d = RD0;
              else if (m1_arvalid) state_d = RD1;
              else if (m1_awvalid) state_d = WR;
            end
          endcase
        end
      end

      RD0, RD1: begin
        if (ar_hs) begin
          ar_sent_d = 1'b1;
        end
        if (r_done) begin
          state_d   = IDLE;
          ar_sent_d = 1'b0;
          if (state_q == RD0) begin
            rr_ptr_d = 2'd1;
          end else begin
            rr_ptr_d = WR_PRIO ? 2'd0 : 2'd2;
          end
        end
      end

      WR: begin
        if (aw_hs) begin
          aw_sent_d = 1'b1;
        end
        if (b_done) begin
          state_d   = IDLE;
          aw_sent_d = 1'b0;
          if (!WR_PRIO) begin
            rr_ptr_d = 2'd0;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Channel routing. Everything defaults to zero so IDLE (and therefore reset)
  // presents no valid/ready and no data to either side. The *_sent guards stop
  // the address from being issued a second time while the master still holds
  // its valid.
  always_comb begin
    m0_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m0_rdata   = '0;
    m0_rresp   = '0;
    m0_rlast   = 1'b0;
    m0_rid     = '0;
    m1_arready = 1'b0;
    m1_rvalid  = 1'b0;
    m1_rdata   = '0;
    m1_rresp   = '0;
    m1_rlast   = 1'b0;
    m1_rid     = '0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bvalid  = 1'b0;
    m1_bresp   = '0;
    m1_bid     = '0;
    s_arvalid  = 1'b0;
    s_araddr   = '0;
    s_arid     = '0;
    s_arlen    = '0;
    s_arsize   = '0;
    s_arburst  = '0;
    s_rready   = 1'b0;
    s_awvalid  = 1'b0;
    s_awaddr   = '0;
    s_awid     = '0;
    s_awlen    = '0;
    s_awsize   = '0;
    s_awburst  = '0;
    s_wvalid   = 1'b0;
    s_wdata    = '0;
    s_wstrb    = '0;
    s_wlast    = 1'b0;
    s_bready   = 1'b0;

    case (state_q)
      RD0: begin
        s_arvalid  = m0_arvalid & ~ar_sent_q;
        s_araddr   = m0_araddr;
        s_arid     = m0_arid;
        s_arlen    = m0_arlen;
        s_arsize   = m0_arsize;
        s_arburst  = m0_arburst;
        m0_arready = s_arready & ~ar_sent_q;
        m0_rvalid  = s_rvalid;
        m0_rdata   = s_rdata;
        m0_rresp   = s_rresp;
        m0_rlast   = s_rlast;
        m0_rid     = s_rid;
        s_rready   = m0_rready;
      end

      RD1: begin
        s_arvalid  = m1_arvalid & ~ar_sent_q;
        s_araddr   = m1_araddr;
        s_arid     = m1_arid;
        s_arlen    = m1_arlen;
        s_arsize   = m1_arsize;
        s_arburst  = m1_arburst;
        m1_arready = s_arready & ~ar_sent_q;
        m1_rvalid  = s_rvalid;
        m1_rdata   = s_rdata;
        m1_rresp   = s_rresp;
        m1_rlast   = s_rlast;
        m1_rid     = s_rid;
        s_rready   = m1_rready;
      end

      WR: begin
        s_awvalid  = m1_awvalid & ~aw_sent_q;
        s_awaddr   = m1_awaddr;
        s_awid     = m1_awid;
        s_awlen    = m1_awlen;
        s_awsize   = m1_awsize;
        s_awburst  = m1_awburst;
        m1_awready = s_awready & ~aw_sent_q;
        s_wvalid   = m1_wvalid;
        s_wdata    = m1_wdata;
        s_wstrb    = m1_wstrb;
        s_wlast    = m1_wlast;
        m1_wready  = s_wready;
        m1_bvalid  = s_bvalid;
        m1_bresp   = s_bresp;
        m1_bid     = s_bid;
        s_bready   = m1_bready;
      end

      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// tb_axi_mem_arbiter
//   Directed bench for axi_mem_arbiter (default parameters, write priority on).
//   The bench plays both upstream masters and the downstream slave, and each
//   scenario task checks the routed signals against hand-computed values.
module tb_axi_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int IW = 4;

  logic            clk;
  logic            rst;

  logic            m0_arvalid, m0_arready;
  logic [AW-1:0]   m0_araddr;
  logic [IW-1:0]   m0_arid;
  logic [7:0]      m0_arlen;
  logic [2:0]      m0_arsize;
  logic [1:0]      m0_arburst;
  logic            m0_rvalid, m0_rready;
  logic [DW-1:0]   m0_rdata;
  logic [1:0]      m0_rresp;
  logic            m0_rlast;
  logic [IW-1:0]   m0_rid;

  logic            m1_arvalid, m1_arready;
  logic [AW-1:0]   m1_araddr;
  logic [IW-1:0]   m1_arid;
  logic [7:0]      m1_arlen;
  logic [2:0]      m1_arsize;
  logic [1:0]      m1_arburst;
  logic            m1_rvalid, m1_rready;
  logic [DW-1:0]   m1_rdata;
  logic [1:0]      m1_rresp;
  logic            m1_rlast;
  logic [IW-1:0]   m1_rid;

  logic            m1_awvalid, m1_awready;
  logic [AW-1:0]   m1_awaddr;
  logic [IW-1:0]   m1_awid;
  logic [7:0]      m1_awlen;
  logic [2:0]      m1_awsize;
  logic [1:0]      m1_awburst;
  logic            m1_wvalid, m1_wready;
  logic [DW-1:0]   m1_wdata;
  logic [DW/8-1:0] m1_wstrb;
  logic            m1_wlast;
  logic            m1_bvalid, m1_bready;
  logic [1:0]      m1_bresp;
  logic [IW-1:0]   m1_bid;

  logic            s_arvalid, s_arready;
  logic [AW-1:0]   s_araddr;
  logic [IW-1:0]   s_arid;
  logic [7:0]      s_arlen;
  logic [2:0]      s_arsize;
  logic [1:0]      s_arburst;
  logic            s_rvalid, s_rready;
  logic [DW-1:0]   s_rdata;
  logic [1:0]      s_rresp;
  logic            s_rlast;
  logic [IW-1:0]   s_rid;
  logic            s_awvalid, s_awready;
  logic [AW-1:0]   s_awaddr;
  logic [IW-1:0]   s_awid;
  logic [7:0]      s_awlen;
  logic [2:0]      s_awsize;
  logic [1:0]      s_awburst;
  logic            s_wvalid, s_wready;
  logic [DW-1:0]   s_wdata;
  logic [DW/8-1:0] s_wstrb;
  logic            s_wlast;
  logic            s_bvalid, s_bready;
  logic [1:0]      s_bresp;
  logic [IW-1:0]   s_bid;

  int checks;
  int errors;

  // Every valid/ready the arbiter drives, gathered so "all quiet" is one compare.
  logic [11:0] vr_outs;
  assign vr_outs = {m0_arready, m0_rvalid, m1_arready, m1_rvalid, m1_awready,
                    m1_wready, m1_bvalid, s_arvalid, s_rready, s_awvalid,
                    s_wvalid, s_bready};

  axi_mem_arbiter #(.AW(AW), .DW(DW), .IW(IW), .WR_PRIO(1'b1)) dut (
    .clk(clk), .rst(rst),
    .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
    .m0_arid(m0_arid), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
    .m0_arburst(m0_arburst), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast), .m0_rid(m0_rid),
    .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
    .m1_arid(m1_arid), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
    .m1_arburst(m1_arburst), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast), .m1_rid(m1_rid),
    .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr),
    .m1_awid(m1_awid), .m1_awlen(m1_awlen), .m1_awsize(m1_awsize),
    .m1_awburst(m1_awburst), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast),
    .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bresp(m1_bresp), .m1_bid(m1_bid),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_arid(s_arid), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rid(s_rid),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_awid(s_awid), .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_wlast(s_wlast), .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_bid(s_bid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge so outputs are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Return every bench-driven input to its idle value; downstream readies high.
  task automatic clear_inputs();
    m0_arvalid = 0; m0_araddr = '0; m0_arid = '0; m0_arlen = '0;
    m0_arsize = 3'd3; m0_arburst = 2'd1; m0_rready = 0;
    m1_arvalid = 0; m1_araddr = '0; m1_arid = '0; m1_arlen = '0;
    m1_arsize = 3'd3; m1_arburst = 2'd1; m1_rready = 0;
    m1_awvalid = 0; m1_awaddr = '0; m1_awid = '0; m1_awlen = '0;
    m1_awsize = 3'd3; m1_awburst = 2'd1;
    m1_wvalid = 0; m1_wdata = '0; m1_wstrb = '0; m1_wlast = 0; m1_bready = 0;
    s_arready = 1; s_rvalid = 0; s_rdata = '0; s_rresp = '0; s_rlast = 0; s_rid = '0;
    s_awready = 1; s_wready = 1; s_bvalid = 0; s_bresp = '0; s_bid = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    m0_arvalid = 1; m1_awvalid = 1; m1_wvalid = 1; m0_rready = 1; m1_bready = 1;
    s_rvalid = 1; s_rdata = 64'h1111_2222_3333_4444; s_bvalid = 1; s_bid = 4'h7;
    m0_araddr = 32'hFFFF_0000; m1_wdata = 64'hAAAA_5555_AAAA_5555;
    #2;
    checks++; if (vr_outs !== 12'h000) begin errors++; $display("[TB] FAIL reset_vr_async: got %h expected %h", vr_outs, 12'h000); end
    tick();
    checks++; if (vr_outs !== 12'h000) begin errors++; $display("[TB] FAIL reset_vr_edge: got %h expected %h", vr_outs, 12'h000); end
    checks++; if ({s_araddr, m0_rdata, s_wdata, m1_bid} !== '0) begin errors++; $display("[TB] FAIL reset_data: got %h %h %h %h expected 0", s_araddr, m0_rdata, s_wdata, m1_bid); end
    clear_inputs();
    tick();
    rst = 0;
  endtask

  task automatic test_single_read();
    m0_araddr = 32'h0200_BFF8; m0_arlen = 8'd0; m0_arid = 4'h3; m0_arvalid = 1; m0_rready = 1;
    #1;
    checks++; if (s_arvalid !== 1'b0) begin errors++; $display("[TB] FAIL single_idle_no_fwd: got %b expected 0", s_arvalid); end
    tick();
    checks++; if (s_arvalid !== 1'b1) begin errors++; $display("[TB] FAIL single_s_arvalid: got %b expected 1", s_arvalid); end
    checks++; if (s_araddr !== 32'h0200_BFF8) begin errors++; $display("[TB] FAIL single_s_araddr: got %h expected %h", s_araddr, 32'h0200_BFF8); end
    checks++; if (s_arid !== 4'h3) begin errors++; $display("[TB] FAIL single_s_arid: got %h expected 3", s_arid); end
    checks++; if (m0_arready !== 1'b1) begin errors++; $display("[TB] FAIL single_m0_arready: got %b expected 1", m0_arready); end
    tick();
    m0_arvalid = 0;
    s_rvalid = 1; s_rdata = 64'hDEAD_BEEF_0123_4567; s_rlast = 1; s_rid = 4'h3;
    #1;
    checks++; if (m0_rvalid !== 1'b1) begin errors++; $display("[TB] FAIL single_m0_rvalid: got %b expected 1", m0_rvalid); end
    checks++; if (m0_rdata !== 64'hDEAD_BEEF_0123_4567) begin errors++; $display("[TB] FAIL single_m0_rdata: got %h expected %h", m0_rdata, 64'hDEAD_BEEF_0123_4567); end
    checks++; if ({m0_rlast, m0_rid} !== {1'b1, 4'h3}) begin errors++; $display("[TB] FAIL single_m0_rlast_rid: got %b %h expected 1 3", m0_rlast, m0_rid); end
    checks++; if (m1_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL single_m1_rvalid: got %b expected 0", m1_rvalid); end
    checks++; if (s_rready !== 1'b1) begin errors++; $display("[TB] FAIL single_s_rready: got %b expected 1", s_rready); end
    tick();
    // Slave still shows a beat: in IDLE it must not reach m0.
    #1;
    checks++; if (m0_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL single_back_idle: got %b expected 0", m0_rvalid); end
    clear_inputs();
  endtask

  task automatic test_round_robin();
    logic [AW-1:0] exp_addr;
    do_reset();
    m0_araddr = 32'h0000_1000; m0_arid = 4'h1; m0_rready = 1;
    m1_araddr = 32'h0000_2000; m1_arid = 4'h2; m1_rready = 1;
    m0_arvalid = 1; m1_arvalid = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_addr = (i % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000;
      checks++; if (s_araddr !== exp_addr) begin errors++; $display("[TB] FAIL rr_grant%0d_addr: got %h expected %h", i, s_araddr, exp_addr); end
      checks++; if ({m0_arready, m1_arready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("[TB] FAIL rr_grant%0d_ready: got %b%b expected one-hot owner", i, m0_arready, m1_arready); end
      tick();
      if (i % 2 == 0) m0_arvalid = 0; else m1_arvalid = 0;
      s_rvalid = 1; s_rlast = 1; s_rdata = 64'hA0 + 64'(i);
      #1;
      checks++; if ({m0_rvalid, m1_rvalid} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("[TB] FAIL rr_r%0d_route: got %b%b expected owner only", i, m0_rvalid, m1_rvalid); end
      checks++; if (((i % 2 == 0) ? m0_rdata : m1_rdata) !== 64'hA0 + 64'(i)) begin errors++; $display("[TB] FAIL rr_r%0d_data: got %h %h expected %h", i, m0_rdata, m1_rdata, 64'hA0 + 64'(i)); end
      tick();
      s_rvalid = 0; s_rlast = 0;
      if (i % 2 == 0) m0_arvalid = 1; else m1_arvalid = 1;
    end
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_write_priority();
    do_reset();
    m1_awaddr = 32'h0200_4000; m1_awid = 4'h5; m1_awvalid = 1; m1_bready = 1;
    m0_araddr = 32'h0200_BFF8; m0_arvalid = 1; m0_rready = 1;
    tick();
    checks++; if ({s_awvalid, m1_awready} !== 2'b11) begin errors++; $display("[TB] FAIL wp_aw_grant: got %b%b expected 11", s_awvalid, m1_awready); end
    checks++; if ({s_arvalid, m0_arready} !== 2'b00) begin errors++; $display("[TB] FAIL wp_ar_blocked: got %b%b expected 00", s_arvalid, m0_arready); end
    checks++; if (s_awid !== 4'h5) begin errors++; $display("[TB] FAIL wp_awid: got %h expected 5", s_awid); end
    tick();
    m1_awvalid = 0;
    m1_wvalid = 1; m1_wdata = 64'h0123_4567_89AB_CDEF; m1_wstrb = 8'hF0; m1_wlast = 1;
    #1;
    checks++; if ({s_wvalid, m1_wready, s_wlast} !== 3'b111) begin errors++; $display("[TB] FAIL wp_w_pass: got %b%b%b expected 111", s_wvalid, m1_wready, s_wlast); end
    checks++; if ({s_wdata, s_wstrb} !== {64'h0123_4567_89AB_CDEF, 8'hF0}) begin errors++; $display("[TB] FAIL wp_w_data: got %h %h expected 0123456789abcdef f0", s_wdata, s_wstrb); end
    tick();
    m1_wvalid = 0; m1_wlast = 0;
    s_bvalid = 1; s_bresp = 2'd0; s_bid = 4'h5;
    #1;
    checks++; if ({m1_bvalid, m1_bresp, m1_bid} !== {1'b1, 2'd0, 4'h5}) begin errors++; $display("[TB] FAIL wp_b_route: got %b %h %h expected 1 0 5", m1_bvalid, m1_bresp, m1_bid); end
    checks++; if (s_bready !== 1'b1) begin errors++; $display("[TB] FAIL wp_s_bready: got %b expected 1", s_bready); end
    tick();
    s_bvalid = 0;
    #1;
    checks++; if (s_arvalid !== 1'b0) begin errors++; $display("[TB] FAIL wp_idle_bubble: got %b expected 0", s_arvalid); end
    tick();
    checks++; if ({s_arvalid, s_araddr} !== {1'b1, 32'h0200_BFF8}) begin errors++; $display("[TB] FAIL wp_read_next: got %b %h expected 1 0200bff8", s_arvalid, s_araddr); end
    tick();
    m0_arvalid = 0; s_rvalid = 1; s_rlast = 1;
    tick();
    clear_inputs();
  endtask

  task automatic test_burst_rready();
    int beat;
    logic rr_exp;
    do_reset();
    m1_araddr = 32'h8000_0040; m1_arlen = 8'd3; m1_arid = 4'hA; m1_arvalid = 1;
    tick();
    checks++; if ({s_arvalid, s_arlen} !== {1'b1, 8'd3}) begin errors++; $display("[TB] FAIL burst_arlen: got %b %h expected 1 03", s_arvalid, s_arlen); end
    tick();
    m1_arvalid = 0;
    beat = 0;
    for (int k = 0; k < 10; k++) begin
      rr_exp = (k % 2 == 0);
      s_rvalid = 1; s_rdata = 64'h100 + 64'(beat); s_rlast = (beat == 3); m1_rready = rr_exp;
      #1;
      checks++; if ({m1_rvalid, m0_rvalid} !== 2'b10) begin errors++; $display("[TB] FAIL burst_k%0d_rvalid: got %b%b expected 10", k, m1_rvalid, m0_rvalid); end
      checks++; if (m1_rdata !== 64'h100 + 64'(beat)) begin errors++; $display("[TB] FAIL burst_k%0d_rdata: got %h expected %h", k, m1_rdata, 64'h100 + 64'(beat)); end
      checks++; if (s_rready !== rr_exp) begin errors++; $display("[TB] FAIL burst_k%0d_s_rready: got %b expected %b", k, s_rready, rr_exp); end
      tick();
      if (rr_exp) beat++;
      if (beat == 4) break;
    end
    checks++; if (beat !== 4) begin errors++; $display("[TB] FAIL burst_beats: got %0d expected 4", beat); end
    // Slave keeps rvalid high after the last beat; the arbiter must be idle.
    #1;
    checks++; if (m1_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL burst_exit: got %b expected 0", m1_rvalid); end
    clear_inputs();
  endtask

  task automatic test_ar_backpressure();
    int hs;
    do_reset();
    s_arready = 0;
    m0_araddr = 32'h0200_0000; m0_arvalid = 1; m0_rready = 1;
    hs = 0;
    tick();
    for (int i = 0; i < 5; i++) begin
      checks++; if ({s_arvalid, m0_arready} !== 2'b10) begin errors++; $display("[TB] FAIL bp_stall%0d: got %b%b expected 10", i, s_arvalid, m0_arready); end
      if (s_arvalid && s_arready) hs++;
      tick();
    end
    s_arready = 1;
    #1;
    checks++; if (m0_arready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release: got %b expected 1", m0_arready); end
    // m0_arvalid deliberately kept high: only the sent guard prevents a re-issue.
    for (int i = 0; i < 3; i++) begin
      if (s_arvalid && s_arready) hs++;
      tick();
    end
    checks++; if (hs !== 1) begin errors++; $display("[TB] FAIL bp_ar_once: got %0d expected 1", hs); end
    m0_arvalid = 0; s_rvalid = 1; s_rlast = 1;
    tick();
    s_rvalid = 0; s_rlast = 0;
  endtask

  task automatic test_reset_mid_write();
    m1_awaddr = 32'h0200_4000; m1_awid = 4'h9; m1_awvalid = 1; m1_bready = 1;
    tick();
    tick();
    m1_awvalid = 0;
    m1_wvalid = 1; m1_wdata = 64'h5A5A; m1_wstrb = 8'hFF; m1_wlast = 1;
    #1;
    checks++; if ({s_awvalid, s_wvalid} !== 2'b01) begin errors++; $display("[TB] FAIL rmw_pre: got %b%b expected 01", s_awvalid, s_wvalid); end
    rst = 1; s_bvalid = 1;
    #1;
    checks++; if (vr_outs !== 12'h000) begin errors++; $display("[TB] FAIL rmw_async: got %h expected %h", vr_outs, 12'h000); end
    tick();
    checks++; if (vr_outs !== 12'h000) begin errors++; $display("[TB] FAIL rmw_edge: got %h expected %h", vr_outs, 12'h000); end
    rst = 0;
    clear_inputs();
    m0_araddr = 32'h0200_BFF8; m0_arvalid = 1; m0_rready = 1;
    tick();
    checks++; if ({s_arvalid, s_araddr, m0_arready} !== {1'b1, 32'h0200_BFF8, 1'b1}) begin errors++; $display("[TB] FAIL rmw_new_read: got %b %h %b expected 1 0200bff8 1", s_arvalid, s_araddr, m0_arready); end
    tick();
    m0_arvalid = 0; s_rvalid = 1; s_rlast = 1; s_rdata = 64'h77;
    #1;
    checks++; if ({m0_rvalid, m0_rdata} !== {1'b1, 64'h77}) begin errors++; $display("[TB] FAIL rmw_new_rdata: got %b %h expected 1 77", m0_rvalid, m0_rdata); end
    tick();
    clear_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_priority();
    test_burst_rready();
    test_ar_backpressure();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
